// File: rtl/dest_scoreboard.sv
// dest_scoreboard: destination-register scoreboard for the in-order pipeline.
// Counts in-flight writers per architectural register. A writer is issued
// when it is captured into ID/EX and retired when WB writes the register
// file. A stall is raised when an instruction in ID reads a pending register.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   flush             ID/EX flush; suppresses issue
//   Issue_WB_EN/Dest  writer entering ID/EX
//   Src1/Src2         ID sources; Src1_Valid / Two_Src mark real reads
//   Fwd_EN            forwarding active: only load-use hazards stall
//   EXE_*             load/writeback/dest of the instruction in EXE
//   WB_WB_EN/WB_Dest  register-file write from WB (retire)
//   stall             combinational hazard stall to IF/ID and ID
//   pending           per-register "counter nonzero" view
//   err               sticky counter overflow/underflow flag
//   stall_cnt         count of cycles with stall asserted
module dest_scoreboard #(
  parameter int NREG      = 16,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            Issue_WB_EN,
  input  logic [3:0]      Issue_Dest,
  input  logic [3:0]      Src1,
  input  logic [3:0]      Src2,
  input  logic            Two_Src,
  input  logic            Src1_Valid,
  input  logic            Fwd_EN,
  input  logic            EXE_MEM_R_EN,
  input  logic            EXE_WB_EN,
  input  logic [3:0]      EXE_Dest,
  input  logic            WB_WB_EN,
  input  logic [3:0]      WB_Dest,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic            err,
  output logic [31:0]     stall_cnt
);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic [31:0]      stall_cnt_q;

  logic [CNT_W-1:0] cnt_s1, cnt_s2;
  logic             byp1, byp2;
  logic             load_use1, load_use2;
  logic             haz1, haz2;
  logic             issue;

  // Hazard detection reads the live counters, not the pending view.
  always_comb begin
    cnt_s1 = '0;
    cnt_s2 = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (Src1 == 4'(r)) cnt_s1 = cnt_q[r];
      if (Src2 == 4'(r)) cnt_s2 = cnt_q[r];
    end
    // A last writer retiring this cycle is already visible in the register file.
    byp1 = (WB_BYPASS != 0) && WB_WB_EN && (WB_Dest == Src1) && (cnt_s1 == CNT_W'(1));
    byp2 = (WB_BYPASS != 0) && WB_WB_EN && (WB_Dest == Src2) && (cnt_s2 == CNT_W'(1));
    load_use1 = EXE_MEM_R_EN && EXE_WB_EN && (EXE_Dest == Src1);
    load_use2 = EXE_MEM_R_EN && EXE_WB_EN && (EXE_Dest == Src2);
    haz1 = Src1_Valid && (Fwd_EN ? load_use1 : ((cnt_s1 != '0) && !byp1));
    haz2 = Two_Src    && (Fwd_EN ? load_use2 : ((cnt_s2 != '0) && !byp2));
    stall = haz1 || haz2;
    issue = Issue_WB_EN && !flush && !stall;
  end

  always_comb begin
    err_d = err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = issue && (Issue_Dest == 4'(r));
      dec = WB_WB_EN && (WB_Dest == 4'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        if (cnt_q[r] == '1) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) pending[r] = (cnt_q[r] != '0);
  end

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dest_scoreboard.sv
// tb_dest_scoreboard: directed stimulus for dest_scoreboard with a
// per-register counting model checked every cycle, plus literal checks.
module tb_dest_scoreboard;

  localparam int NREG  = 16;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RST, flush, Issue_WB_EN, Two_Src, Src1_Valid, Fwd_EN;
  logic        EXE_MEM_R_EN, EXE_WB_EN, WB_WB_EN;
  logic [3:0]  Issue_Dest, Src1, Src2, EXE_Dest, WB_Dest;
  logic        stall, err;
  logic [15:0] pending;
  logic [31:0] stall_cnt;

  dest_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .WB_BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .Issue_WB_EN(Issue_WB_EN), .Issue_Dest(Issue_Dest),
    .Src1(Src1), .Src2(Src2), .Two_Src(Two_Src), .Src1_Valid(Src1_Valid),
    .Fwd_EN(Fwd_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN), .EXE_WB_EN(EXE_WB_EN),
    .EXE_Dest(EXE_Dest), .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest),
    .stall(stall), .pending(pending), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state: plain per-register writer counts.
  int          m_cnt [NREG];
  bit          m_err;
  int unsigned m_scnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input int s, input bit valid);
    if (!valid) return 0;
    if (Fwd_EN) return EXE_MEM_R_EN && EXE_WB_EN && (int'(EXE_Dest) == s);
    if (m_cnt[s] == 0) return 0;
    if (WB_WB_EN && int'(WB_Dest) == s && m_cnt[s] == 1) return 0;
    return 1;
  endfunction

  function automatic bit m_stall();
    return m_hazard(int'(Src1), Src1_Valid) || m_hazard(int'(Src2), Two_Src);
  endfunction

  function automatic logic [15:0] m_pending();
    logic [15:0] p = '0;
    for (int i = 0; i < NREG; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
      m_err  = 0;
      m_scnt = 0;
    end else begin
      bit st, iss;
      int d, w;
      st  = m_stall();
      iss = Issue_WB_EN && !flush && !st;
      d   = int'(Issue_Dest);
      w   = int'(WB_Dest);
      if (st) m_scnt++;
      if (!(iss && WB_WB_EN && d == w)) begin
        if (iss) begin
          if (m_cnt[d] == MAXC) m_err = 1; else m_cnt[d]++;
        end
        if (WB_WB_EN) begin
          if (m_cnt[w] == 0) m_err = 1; else m_cnt[w]--;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("stall",     {31'd0, stall}, {31'd0, m_stall()});
      chk("pending",   {16'd0, pending}, {16'd0, m_pending()});
      chk("err",       {31'd0, err}, {31'd0, m_err});
      chk("stall_cnt", stall_cnt, m_scnt);
    end
  end

  task automatic idle();
    flush = 0; Issue_WB_EN = 0; Issue_Dest = 0;
    Src1 = 0; Src2 = 0; Two_Src = 0; Src1_Valid = 0;
    Fwd_EN = 0; EXE_MEM_R_EN = 0; EXE_WB_EN = 0; EXE_Dest = 0;
    WB_WB_EN = 0; WB_Dest = 0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic issue_reg(input logic [3:0] r);
    idle(); Issue_WB_EN = 1; Issue_Dest = r; step();
  endtask

  task automatic retire_reg(input logic [3:0] r);
    idle(); WB_WB_EN = 1; WB_Dest = r; step();
  endtask

  initial begin
    idle(); RST = 1;
    step(); step();
    RST = 0; chk_en = 1;
    @(negedge CLK);
    chk("rst_pending", {16'd0, pending}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    step();

    // Single writer, then read with same-cycle bypass.
    issue_reg(4'd3);
    idle(); Src1 = 3; Src1_Valid = 1;
    @(negedge CLK);
    chk("r3_pending", {16'd0, pending}, 32'h0008);
    chk("r3_stall", {31'd0, stall}, 32'h1);
    step();
    idle(); Src1 = 3; Src1_Valid = 1; WB_WB_EN = 1; WB_Dest = 3;
    @(negedge CLK);
    chk("r3_bypass", {31'd0, stall}, 32'h0);
    step();
    idle();
    @(negedge CLK);
    chk("r3_cleared", {16'd0, pending}, 32'h0);
    step();

    // Two writers: bypass only applies to the last one.
    issue_reg(4'd5); issue_reg(4'd5);
    idle(); Src2 = 5; Two_Src = 1; WB_WB_EN = 1; WB_Dest = 5;
    @(negedge CLK);
    chk("r5_first_retire_stall", {31'd0, stall}, 32'h1);
    step();
    idle(); Src2 = 5; Two_Src = 1; WB_WB_EN = 1; WB_Dest = 5;
    @(negedge CLK);
    chk("r5_second_retire_stall", {31'd0, stall}, 32'h0);
    step();
    idle();
    @(negedge CLK);
    chk("r5_cleared", {16'd0, pending}, 32'h0);

    // Flushed issue is dropped; simultaneous issue+retire holds the count.
    idle(); flush = 1; Issue_WB_EN = 1; Issue_Dest = 7; step();
    idle();
    @(negedge CLK);
    chk("r7_flush", {16'd0, pending}, 32'h0);
    issue_reg(4'd7);
    idle(); Issue_WB_EN = 1; Issue_Dest = 7; WB_WB_EN = 1; WB_Dest = 7; step();
    idle();
    @(negedge CLK);
    chk("r7_same_cycle", {16'd0, pending}, 32'h0080);
    retire_reg(4'd7);

    // Forwarding: only load-use stalls; a stalled issue is suppressed.
    issue_reg(4'd2);
    idle(); Fwd_EN = 1; EXE_MEM_R_EN = 1; EXE_WB_EN = 1; EXE_Dest = 2;
    Src1 = 2; Src1_Valid = 1; Issue_WB_EN = 1; Issue_Dest = 6;
    @(negedge CLK);
    chk("load_use_stall", {31'd0, stall}, 32'h1);
    step();
    idle(); Fwd_EN = 1; EXE_WB_EN = 1; EXE_Dest = 2; Src1 = 2; Src1_Valid = 1;
    @(negedge CLK);
    chk("fwd_no_load", {31'd0, stall}, 32'h0);
    chk("fwd_pending", {16'd0, pending}, 32'h0004);
    step();
    retire_reg(4'd2);

    // Underflow and overflow set the sticky error; reset clears it.
    retire_reg(4'd9);
    idle();
    @(negedge CLK);
    chk("underflow_err", {31'd0, err}, 32'h1);
    chk("underflow_pending", {16'd0, pending}, 32'h0);
    for (int i = 0; i < 4; i++) issue_reg(4'd4);
    idle();
    @(negedge CLK);
    chk("overflow_pending", {16'd0, pending}, 32'h0010);
    chk("overflow_err", {31'd0, err}, 32'h1);
    RST = 1; step(); RST = 0;
    @(negedge CLK);
    chk("rst2_err", {31'd0, err}, 32'h0);
    chk("rst2_pending", {16'd0, pending}, 32'h0);
    chk("rst2_stall_cnt", stall_cnt, 32'h0);

    // Held hazard counts stall cycles; reset discards pending writers.
    issue_reg(4'd1); issue_reg(4'd1);
    idle(); Src1 = 1; Src1_Valid = 1;
    for (int i = 0; i < 4; i++) step();
    @(negedge CLK);
    chk("stall_cnt_4", stall_cnt, 32'd4);
    RST = 1; step(); RST = 0;
    @(negedge CLK);
    chk("rst3_stall", {31'd0, stall}, 32'h0);
    chk("rst3_stall_cnt", stall_cnt, 32'h0);
    step(); step();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
